// File: rtl/stack_unit_pkg.sv
// Shared defaults, derived pointer width and the operation codes decoded
// from the push/pop inputs by the stack controller.
package stack_unit_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int DEPTH_DEF = 8;
    localparam int PTR_W     = $clog2(DEPTH_DEF);
    localparam int CNT_W     = PTR_W + 1;

    typedef enum logic [2:0] {
        OP_IDLE    = 3'b000,
        OP_PUSH    = 3'b100,
        OP_POP     = 3'b101,
        OP_REPLACE = 3'b110
    } op_e;

endpackage

// File: rtl/stack_unit_mem.sv
// Stack storage: one synchronous write port and two asynchronous read ports.
// Deliberately has no reset; contents are don't-care until written.
module stack_mem #(
    parameter int WIDTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr_a,
    output logic [WIDTH-1:0] rdata_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_b
);

    logic [WIDTH-1:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/stack_unit.sv
// LIFO stack controller: stack pointer, registered dout, sticky overflow and
// underflow flags; storage lives in stack_mem.
module stack_unit
    import stack_unit_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   tos,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       top,
    output logic [WIDTH-1:0]       dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full,
    output logic                   ovf,
    output logic                   unf
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [CW-1:0]    sp;
    logic [CW-1:0]    sp_m1;
    op_e              op;
    logic             we;
    logic [AW-1:0]    waddr;
    logic [WIDTH-1:0] top_data;
    logic [WIDTH-1:0] unused_next_data;

    assign sp_m1 = sp - CW'(1);
    assign empty = (sp == '0);
    assign full  = (sp == CW'(DEPTH));
    assign top   = empty ? '0 : top_data;
    assign count = sp;

    always_comb begin
        op = OP_IDLE;
        if (push && pop) begin
            op = OP_REPLACE;
        end else if (push) begin
            op = OP_PUSH;
        end else if (pop) begin
            op = OP_POP;
        end
    end

    // A replace on a non-empty stack overwrites the top; a replace on an
    // empty stack degrades to an ordinary push at slot 0.
    always_comb begin
        we    = 1'b0;
        waddr = sp[AW-1:0];
        if (op == OP_PUSH && !full) begin
            we = 1'b1;
        end else if (op == OP_REPLACE) begin
            we = 1'b1;
            if (!empty) begin
                waddr = sp_m1[AW-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sp   <= '0;
            dout <= '0;
            ovf  <= 1'b0;
            unf  <= 1'b0;
        end else begin
            case (op)
                OP_PUSH: begin
                    if (full) begin
                        ovf <= 1'b1;
                    end else begin
                        sp <= sp + CW'(1);
                    end
                    if (tos) begin
                        dout <= top;
                    end
                end
                OP_POP: begin
                    if (empty) begin
                        unf <= 1'b1;
                    end else begin
                        dout <= top;
                        sp   <= sp_m1;
                    end
                end
                OP_REPLACE: begin
                    if (empty) begin
                        sp  <= sp + CW'(1);
                        unf <= 1'b1;
                        if (tos) begin
                            dout <= top;
                        end
                    end else begin
                        dout <= top;
                    end
                end
                default: begin
                    if (tos) begin
                        dout <= top;
                    end
                end
            endcase
        end
    end

    // The mem[sp] read port is kept for future lookahead use.
    stack_mem #(
        .WIDTH (WIDTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .we      (we),
        .waddr   (waddr),
        .wdata   (din),
        .raddr_a (sp_m1[AW-1:0]),
        .rdata_a (top_data),
        .raddr_b (sp[AW-1:0]),
        .rdata_b (unused_next_data)
    );

endmodule

// File: tb/tb_stack_unit.sv
// Self-checking bench for stack_unit: directed scenarios plus randomized
// traffic compared against a queue-based LIFO reference model.
module tb_stack_unit;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;

    logic             clk;
    logic             rst;
    logic             push;
    logic             pop;
    logic             tos;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] top;
    logic [WIDTH-1:0] dout;
    logic [3:0]       count;
    logic             empty;
    logic             full;
    logic             ovf;
    logic             unf;

    int n_cmp;
    int n_err;

    // Reference model: the stack as a queue, top at the back.
    logic [WIDTH-1:0] m_q[$];
    logic [WIDTH-1:0] m_dout;
    logic             m_ovf;
    logic             m_unf;

    stack_unit #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .tos   (tos),
        .din   (din),
        .top   (top),
        .dout  (dout),
        .count (count),
        .empty (empty),
        .full  (full),
        .ovf   (ovf),
        .unf   (unf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [WIDTH-1:0] model_top();
        return (m_q.size() == 0) ? '0 : m_q[m_q.size()-1];
    endfunction

    task automatic model_step(input logic p, input logic q, input logic t,
                              input logic [WIDTH-1:0] d);
        logic [WIDTH-1:0] old_top;
        int               n;
        old_top = model_top();
        n       = m_q.size();
        if (p && q) begin
            if (n == 0) begin
                m_q.push_back(d);
                m_unf = 1'b1;
                if (t) m_dout = old_top;
            end else begin
                m_dout = old_top;
                m_q[n-1] = d;
            end
        end else if (p) begin
            if (t) m_dout = old_top;
            if (n == DEPTH) m_ovf = 1'b1;
            else m_q.push_back(d);
        end else if (q) begin
            if (n == 0) m_unf = 1'b1;
            else m_dout = m_q.pop_back();
        end else if (t) begin
            m_dout = old_top;
        end
    endtask

    task automatic model_clear();
        m_q.delete();
        m_dout = '0;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
    endtask

    // Drive one operation across one rising edge; returns at edge + 1.
    task automatic do_op(input logic p, input logic q, input logic t,
                         input logic [WIDTH-1:0] d);
        push = p;
        pop  = q;
        tos  = t;
        din  = d;
        @(posedge clk);
        model_step(p, q, t, d);
        #1;
        push = 1'b0;
        pop  = 1'b0;
        tos  = 1'b0;
        din  = '0;
    endtask

    task automatic do_reset();
        push = 1'b0;
        pop  = 1'b0;
        tos  = 1'b0;
        din  = '0;
        rst  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        model_clear();
    endtask

    task automatic test_reset();
        push = 1'b0;
        pop  = 1'b0;
        tos  = 1'b0;
        din  = '0;
        rst  = 1'b0;
        #12;
        n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL reset_count got %0d exp 0", count); end
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL reset_empty got %b exp 1", empty); end
        n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL reset_full got %b exp 0", full); end
        n_cmp++; if (top !== 8'h00) begin n_err++; $display("FAIL reset_top got %h exp 00", top); end
        n_cmp++; if (dout !== 8'h00) begin n_err++; $display("FAIL reset_dout got %h exp 00", dout); end
        n_cmp++; if (ovf !== 1'b0 || unf !== 1'b0) begin
            n_err++; $display("FAIL reset_flags got ovf=%b unf=%b exp 0 0", ovf, unf);
        end
        @(negedge clk);
        rst = 1'b1;
        model_clear();
    endtask

    task automatic test_lifo();
        logic [WIDTH-1:0] exp_q[$];
        logic [WIDTH-1:0] exp_v;
        do_reset();
        exp_q = '{8'h11, 8'h22, 8'h33};
        foreach (exp_q[i]) do_op(1'b1, 1'b0, 1'b0, exp_q[i]);
        n_cmp++; if (count !== 4'd3) begin n_err++; $display("FAIL lifo_count got %0d exp 3", count); end
        n_cmp++; if (top !== 8'h33) begin n_err++; $display("FAIL lifo_top got %h exp 33", top); end
        for (int i = 0; i < 3; i++) begin
            do_op(1'b0, 1'b1, 1'b0, '0);
            exp_v = exp_q.pop_back();
            n_cmp++; if (dout !== exp_v) begin n_err++; $display("FAIL lifo_pop%0d got %h exp %h", i, dout, exp_v); end
        end
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL lifo_empty got %b exp 1", empty); end
        n_cmp++; if (unf !== 1'b0) begin n_err++; $display("FAIL lifo_unf got %b exp 0", unf); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            do_op(1'b1, 1'b0, 1'b0, 8'(8'hA0 + i));
            if (i == DEPTH - 2) begin
                n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL ovf_not_full got %b exp 0", full); end
            end
        end
        n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL ovf_early got %b exp 0", ovf); end
        do_op(1'b1, 1'b0, 1'b0, 8'hFF);
        n_cmp++; if (full !== 1'b1) begin n_err++; $display("FAIL ovf_full got %b exp 1", full); end
        n_cmp++; if (ovf !== 1'b1) begin n_err++; $display("FAIL ovf_flag got %b exp 1", ovf); end
        n_cmp++; if (count !== 4'(DEPTH)) begin n_err++; $display("FAIL ovf_count got %0d exp %0d", count, DEPTH); end
        n_cmp++; if (top !== 8'hA7) begin n_err++; $display("FAIL ovf_top got %h exp a7", top); end
    endtask

    task automatic test_underflow();
        do_reset();
        do_op(1'b1, 1'b0, 1'b0, 8'h5A);
        do_op(1'b0, 1'b1, 1'b0, '0);
        do_op(1'b0, 1'b1, 1'b0, '0);
        n_cmp++; if (unf !== 1'b1) begin n_err++; $display("FAIL unf_flag got %b exp 1", unf); end
        n_cmp++; if (dout !== 8'h5A) begin n_err++; $display("FAIL unf_dout got %h exp 5a", dout); end
        n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL unf_count got %0d exp 0", count); end
        do_op(1'b1, 1'b0, 1'b0, 8'h05);
        n_cmp++; if (count !== 4'd1) begin n_err++; $display("FAIL unf_push_count got %0d exp 1", count); end
        n_cmp++; if (unf !== 1'b1) begin n_err++; $display("FAIL unf_sticky got %b exp 1", unf); end
    endtask

    task automatic test_replace();
        do_reset();
        do_op(1'b1, 1'b0, 1'b0, 8'h10);
        do_op(1'b1, 1'b0, 1'b0, 8'h20);
        do_op(1'b1, 1'b1, 1'b0, 8'h99);
        n_cmp++; if (dout !== 8'h20) begin n_err++; $display("FAIL repl_dout got %h exp 20", dout); end
        n_cmp++; if (top !== 8'h99) begin n_err++; $display("FAIL repl_top got %h exp 99", top); end
        n_cmp++; if (count !== 4'd2) begin n_err++; $display("FAIL repl_count got %0d exp 2", count); end
        do_reset();
        do_op(1'b1, 1'b1, 1'b0, 8'h3C);
        n_cmp++; if (count !== 4'd1 || top !== 8'h3C || unf !== 1'b1) begin
            n_err++; $display("FAIL repl_empty got count=%0d top=%h unf=%b exp 1 3c 1", count, top, unf);
        end
    endtask

    task automatic test_tos_reset();
        do_reset();
        do_op(1'b1, 1'b0, 1'b0, 8'h44);
        do_op(1'b0, 1'b0, 1'b1, '0);
        n_cmp++; if (dout !== 8'h44) begin n_err++; $display("FAIL tos_dout got %h exp 44", dout); end
        n_cmp++; if (count !== 4'd1) begin n_err++; $display("FAIL tos_count got %0d exp 1", count); end
        #2;
        rst = 1'b0;
        #1;
        n_cmp++; if (count !== 4'd0 || dout !== 8'h00 || empty !== 1'b1 || top !== 8'h00) begin
            n_err++;
            $display("FAIL async_reset got count=%0d dout=%h empty=%b top=%h exp 0 00 1 00",
                     count, dout, empty, top);
        end
        @(negedge clk);
        rst = 1'b1;
        model_clear();
        do_op(1'b0, 1'b0, 1'b1, '0);
        n_cmp++; if (dout !== 8'h00 || unf !== 1'b0) begin
            n_err++; $display("FAIL tos_empty got dout=%h unf=%b exp 00 0", dout, unf);
        end
    endtask

    task automatic test_random();
        logic             p, q, t;
        logic [WIDTH-1:0] d;
        logic [WIDTH-1:0] exp_top;
        for (int r = 0; r < 4; r++) begin
            do_reset();
            for (int i = 0; i < 100; i++) begin
                p = ($urandom_range(0, 99) < 30 + 15 * r);
                q = ($urandom_range(0, 99) < 40);
                t = !q && ($urandom_range(0, 3) == 0);
                d = 8'($urandom_range(0, 255));
                do_op(p, q, t, d);
                exp_top = model_top();
                n_cmp++; if (count !== 4'(m_q.size())) begin
                    n_err++; $display("FAIL rnd_count r%0d c%0d got %0d exp %0d", r, i, count, m_q.size());
                end
                n_cmp++; if (top !== exp_top) begin
                    n_err++; $display("FAIL rnd_top r%0d c%0d got %h exp %h", r, i, top, exp_top);
                end
                n_cmp++; if (dout !== m_dout) begin
                    n_err++; $display("FAIL rnd_dout r%0d c%0d got %h exp %h", r, i, dout, m_dout);
                end
                n_cmp++; if (empty !== (m_q.size() == 0) || full !== (m_q.size() == DEPTH)) begin
                    n_err++; $display("FAIL rnd_level r%0d c%0d got empty=%b full=%b size %0d",
                                      r, i, empty, full, m_q.size());
                end
                n_cmp++; if (ovf !== m_ovf || unf !== m_unf) begin
                    n_err++; $display("FAIL rnd_flags r%0d c%0d got ovf=%b unf=%b exp %b %b",
                                      r, i, ovf, unf, m_ovf, m_unf);
                end
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        model_clear();
        test_reset();
        test_lifo();
        test_overflow();
        test_underflow();
        test_replace();
        test_tos_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/stack_unit.md
STACK_UNIT -- requirements
Module: stack_unit

Interface
REQ-001 The block SHALL expose parameter WIDTH, default 8, meaning the data word width in bits.
REQ-002 The block SHALL expose parameter DEPTH, default 8, meaning the number of stack entries; DEPTH SHALL be a power of two, at least 2.
REQ-003 clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low; the block is in reset while rst=0.
REQ-005 push  input  1  write din onto the stack this cycle.
REQ-006 pop  input  1  remove the top entry this cycle.
REQ-007 tos  input  1  latch the current top entry into dout.
REQ-008 din  input  WIDTH  data to push.
REQ-009 top  output  WIDTH  combinational peek of the top entry: mem[sp-1], or 0 when empty.
REQ-010 dout  output  WIDTH  registered data result of the last pop or tos.
REQ-011 count  output  log2(DEPTH)+1  number of valid entries.
REQ-012 empty  output  1  high when count=0.
REQ-013 full  output  1  high when count=DEPTH.
REQ-014 ovf  output  1  sticky overflow flag.
REQ-015 unf  output  1  sticky underflow flag.

Function
REQ-016 The stack pointer sp SHALL equal count; the top entry SHALL be mem[sp-1]; storage SHALL be a register array, with no initial values required.
REQ-017 A push-only cycle with full=0 SHALL write din to mem[sp] and increment sp by 1.
REQ-018 A push-only cycle with full=1 SHALL leave memory and sp unchanged and set ovf=1.
REQ-019 A pop-only cycle with empty=0 SHALL load dout with mem[sp-1] and decrement sp by 1.
REQ-020 A pop-only cycle with empty=1 SHALL leave sp and dout unchanged and set unf=1.
REQ-021 A tos cycle with empty=0 SHALL load dout with mem[sp-1] and leave sp unchanged; with empty=1 it SHALL load dout with 0 and leave unf unaffected.
REQ-022 A cycle with push=1 and pop=1 and empty=0 SHALL load dout with mem[sp-1], write din to mem[sp-1] (replace top), and leave sp unchanged.
REQ-023 A cycle with push=1 and pop=1 and empty=1 SHALL behave as a push-only cycle (sp 0->1) and set unf=1.
REQ-024 When pop=1, pop SHALL take priority over tos for the dout source; tos combined with push-only SHALL load dout with the pre-push top.
REQ-025 Each operation SHALL take effect in the cycle it is presented: dout, count, full and empty are valid the cycle after the edge; top reflects the new sp in the same cycle the edge occurs.
REQ-026 ovf and unf SHALL remain set until reset; no other operation clears them.
REQ-027 top, empty and full SHALL be purely combinational from sp and the memory; every other output SHALL be registered.

Reset
REQ-028 While rst=0, sp, dout, ovf and unf SHALL be 0 and count=0, empty=1, full=0, top=0, regardless of clk.
REQ-029 Reset asserted during an operation SHALL abort that operation without a partial sp update; memory contents are don't-care after reset.
REQ-030 The first edge after rst rises SHALL be processed as a normal operation cycle.

Structure
REQ-031 The shared package SHALL hold WIDTH and DEPTH defaults, the derived pointer width, and the stack opcode constants (PUSH=3'b100, POP=3'b101) used by the controller.
REQ-032 The storage array SHALL be the sub-module stack_mem: a single write port and two asynchronous read ports (sp-1, sp), with no reset.
REQ-033 Pointer, flag and dout logic SHALL reside in stack_unit.

Verification
REQ-034 Reset, then push 0x11, 0x22, 0x33 -> count=3, top=0x33; three pops -> dout=0x33, then 0x22, then 0x11; empty=1, unf=0.
REQ-035 Push 0xA0+i for i=0..DEPTH-1, then one more push of 0xFF -> full=1, ovf=1, count=DEPTH, top=0xA7 (DEPTH=8).
REQ-036 Pop when empty -> unf=1, dout unchanged, count=0; a subsequent push of 0x05 -> count=1, unf remains 1.
REQ-037 Stack {0x10,0x20}, push=pop=1 with din=0x99 -> dout=0x20, top=0x99, count=2.
REQ-038 Stack {0x44}, tos=1 -> dout=0x44, count=1; drive rst=0 mid-cycle -> count=0, dout=0, empty=1 immediately, without a clock edge.
